// File: rtl/blackbox_pkg.sv
// Shared types and constants for the blackbox prober, which sweeps a
// 3-input combinational lab circuit and records its truth table.
package blackbox_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;

  // Truth table of the reference circuit z = ~b & (x | ~d), index {x,b,d}
  localparam logic [7:0] BLACKBOX_GOLDEN = 8'h31;

endpackage

// File: rtl/blackbox_settle_counter.sv
// Settle-time counter: counts wait cycles for one probe vector and flags the
// terminal count. The raw count is exported only with BLACKBOX_PROBER_STABILITY_EN.
module blackbox_settle_counter #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
`ifdef BLACKBOX_PROBER_STABILITY_EN
  output logic [CNT_W-1:0] o_cnt,
`endif
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over enable so the terminal-count cycle wraps the count to zero
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef BLACKBOX_PROBER_STABILITY_EN
  assign o_cnt = r_cnt;
`endif
  assign o_tc = (r_cnt == CNT_W'(SETTLE));

endmodule

// File: rtl/blackbox_prober.sv
// Bench-side initiator that drives all 8 {x,b,d} vectors into a lab circuit and
// captures its truth table. BLACKBOX_PROBER_STABILITY_EN adds a settle-glitch detector.
module blackbox_prober
  import blackbox_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_expected,
  input  logic       i_probe_z,
  output logic       o_probe_x,
  output logic       o_probe_b,
  output logic       o_probe_d,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_truth_table,
  output logic       o_match,
  output logic       o_unstable
);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_table;
  logic             r_match;

  state_t           w_state_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [7:0]       w_table_next;
  logic             w_match_next;
  logic             w_cnt_clear;
  logic             w_cnt_en;
  logic             w_tc;
`ifdef BLACKBOX_PROBER_STABILITY_EN
  logic [CNT_W-1:0] w_cnt;
`endif

  blackbox_settle_counter #(
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) u_settle (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
`ifdef BLACKBOX_PROBER_STABILITY_EN
    .o_cnt   (w_cnt),
`endif
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_table <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_table <= w_table_next;
      r_match <= w_match_next;
    end
  end

  // idx stops at 7 after a sweep so the probes keep showing the last vector
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_table_next = r_table;
    w_match_next = r_match;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_table_next = '0;
          w_match_next = 1'b0;
          w_idx_next   = '0;
          w_cnt_clear  = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          w_cnt_clear         = 1'b1;
          w_table_next[r_idx] = i_probe_z;
          if (r_idx == IDX_W'(NUM_VEC - 1)) begin
            w_state_next = DONE;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      DONE: begin
        w_match_next = (r_table == i_expected);
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign {o_probe_x, o_probe_b, o_probe_d} = r_idx;
  assign o_busy        = (r_state == WAIT);
  assign o_done        = (r_state == DONE);
  assign o_truth_table = r_table;
  assign o_match       = r_match;

`ifdef BLACKBOX_PROBER_STABILITY_EN
  localparam logic [CNT_W-1:0] SHADOW_AT = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);

  logic r_shadow;
  logic r_unstable;
  logic w_ref;

  // With no settle time the shadow and the sample are the same cycle
  assign w_ref = (SETTLE == 0) ? i_probe_z : r_shadow;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow   <= 1'b0;
      r_unstable <= 1'b0;
    end else begin
      if (r_state == WAIT && w_cnt == SHADOW_AT) begin
        r_shadow <= i_probe_z;
      end
      if (r_state == IDLE && i_start) begin
        r_unstable <= 1'b0;
      end else if (r_state == WAIT && w_tc && i_probe_z != w_ref) begin
        r_unstable <= 1'b1;
      end
    end
  end

  assign o_unstable = r_unstable;
`else
  assign o_unstable = 1'b0;
`endif

endmodule

// File: tb/tb_blackbox_prober.sv
// Bench for blackbox_prober: two instances (SETTLE=2 and SETTLE=0) sweep a
// modelled lab circuit; BLACKBOX_PROBER_STABILITY_EN enables the glitch expectations.
module tb_blackbox_prober;
  import blackbox_pkg::*;

`ifdef BLACKBOX_PROBER_STABILITY_EN
  localparam bit STAB_ON = 1'b1;
`else
  localparam bit STAB_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] expected;
  int         mode;       // 0 golden, 1 stuck ~b, 2 golden with a late glitch on vector 3

  logic       zA[2];
  logic       xA[2], bA[2], dA[2];
  logic       busyA[2], doneA[2], matchA[2], unstA[2];
  logic [7:0] ttA[2];

  int nChecks = 0;
  int nErr    = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  blackbox_prober #(.SETTLE(2), .CNT_W(4)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_expected(expected),
    .i_probe_z(zA[0]), .o_probe_x(xA[0]), .o_probe_b(bA[0]), .o_probe_d(dA[0]),
    .o_busy(busyA[0]), .o_done(doneA[0]), .o_truth_table(ttA[0]),
    .o_match(matchA[0]), .o_unstable(unstA[0])
  );

  blackbox_prober #(.SETTLE(0), .CNT_W(4)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_expected(expected),
    .i_probe_z(zA[1]), .o_probe_x(xA[1]), .o_probe_b(bA[1]), .o_probe_d(dA[1]),
    .o_busy(busyA[1]), .o_done(doneA[1]), .o_truth_table(ttA[1]),
    .o_match(matchA[1]), .o_unstable(unstA[1])
  );

  function automatic int settleOf(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // The lab circuit under characterisation, index v = {x,b,d}
  function automatic logic labZ(input logic [2:0] v, input int m);
    if (m == 1) return ~v[1];
    return ~v[1] & (v[2] | ~v[0]);
  endfunction

  // Glitching circuit: vector 3 flips its output once it has been held 3+ cycles
  logic       glitch[2] = '{1'b0, 1'b0};
  int         age[2]    = '{0, 0};
  logic [2:0] prevP[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [2:0] p;
      p = {xA[i], bA[i], dA[i]};
      if (p == prevP[i]) age[i] = age[i] + 1;
      else age[i] = 0;
      prevP[i] = p;
      glitch[i] = (mode == 2) && (p == 3'd3) && (age[i] >= 2);
    end
  end

  assign zA[0] = labZ({xA[0], bA[0], dA[0]}, mode) ^ glitch[0];
  assign zA[1] = labZ({xA[1], bA[1], dA[1]}, mode) ^ glitch[1];

  // Value the prober should record for vector v given its settle time
  function automatic logic fz(input int v, input int s, input int m);
    return labZ(3'(v), m) | ((m == 2) && (v == 3) && (s >= 2));
  endfunction

  // Table visible in cycle k of a sweep: vector v is recorded after (v+1)*(s+1) cycles
  function automatic logic [7:0] tableAt(input int s, input int k, input int m);
    logic [7:0] t;
    t = '0;
    for (int v = 0; v < 8; v++) begin
      if ((v + 1) * (s + 1) < k) t[v] = fz(v, s, m);
    end
    return t;
  endfunction

  // Model: k counts cycles since the accepted start edge (k=1 is the first busy cycle)
  bit         run[2]    = '{1'b0, 1'b0};
  int         k[2]      = '{0, 0};
  logic [7:0] mTab[2]   = '{8'h00, 8'h00};
  logic       mMatch[2] = '{1'b0, 1'b0};
  logic       mUnst[2]  = '{1'b0, 1'b0};
  int         mProbe[2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s, len;
      s   = settleOf(i);
      len = 8 * (s + 1);
      if (rst) begin
        run[i] = 1'b0; k[i] = 0; mTab[i] = 8'h00;
        mMatch[i] = 1'b0; mUnst[i] = 1'b0; mProbe[i] = 0;
      end else if (run[i] && k[i] == len + 1) begin
        run[i]    = 1'b0;
        mMatch[i] = (mTab[i] == expected);
      end else if (run[i]) begin
        k[i]      = k[i] + 1;
        mTab[i]   = tableAt(s, k[i], mode);
        mProbe[i] = (k[i] <= len) ? (k[i] - 1) / (s + 1) : 7;
        if (STAB_ON && mode == 2 && s >= 2 && k[i] > 4 * (s + 1)) mUnst[i] = 1'b1;
      end else if (start) begin
        run[i] = 1'b1; k[i] = 1; mTab[i] = 8'h00;
        mMatch[i] = 1'b0; mUnst[i] = 1'b0; mProbe[i] = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    nChecks++;
    if (got !== want) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        int len;
        len = 8 * (settleOf(i) + 1);
        checkOutput($sformatf("busy[%0d]", i), busyA[i], run[i] && k[i] <= len);
        checkOutput($sformatf("done[%0d]", i), doneA[i], run[i] && k[i] == len + 1);
        checkOutput($sformatf("probes[%0d]", i), {xA[i], bA[i], dA[i]}, 8'(mProbe[i]));
        checkOutput($sformatf("table[%0d]", i), ttA[i], mTab[i]);
        checkOutput($sformatf("match[%0d]", i), matchA[i], mMatch[i]);
        checkOutput($sformatf("unstable[%0d]", i), unstA[i], mUnst[i]);
      end
    end
  end

  int busyCnt[2] = '{0, 0};
  int doneCnt[2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busyA[i] === 1'b1) busyCnt[i] = busyCnt[i] + 1;
      if (doneA[i] === 1'b1) doneCnt[i] = doneCnt[i] + 1;
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input int n);
    rst   = r;
    start = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDone(input int limit);
    int c;
    c = 0;
    while (doneA[0] !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    checkOutput("done_seen", doneA[0], 1'b1);
  endtask

  task automatic pulseStart();
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0[2], d0[2], c;
    rst = 1'b1; start = 1'b0; expected = BLACKBOX_GOLDEN; mode = 0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3);
    checkEn = 1'b1;
    checkOutput("reset_busy", busyA[0], 1'b0);
    checkOutput("reset_table", ttA[0], 8'h00);
    checkOutput("reset_probes", {xA[0], bA[0], dA[0]}, 8'h00);
    checkOutput("reset_match", matchA[1], 1'b0);
    applyStimulus(1'b0, 1'b0, 2);

    $display("[TB] golden circuit sweep");
    b0 = busyCnt; d0 = doneCnt;
    pulseStart();
    waitDone(40);
    checkOutput("golden_table_done", ttA[0], 8'h31);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("golden_match2", matchA[0], 1'b1);
    checkOutput("golden_table0", ttA[1], 8'h31);
    checkOutput("golden_match0", matchA[1], 1'b1);
    checkOutput("golden_busy2", 8'(busyCnt[0] - b0[0]), 8'd24);
    checkOutput("golden_busy0", 8'(busyCnt[1] - b0[1]), 8'd8);
    checkOutput("golden_dones", 8'(doneCnt[0] - d0[0]), 8'd1);
    checkOutput("golden_hold_probes", {xA[0], bA[0], dA[0]}, 8'd7);

    $display("[TB] faulty circuit sweep");
    mode = 1;
    pulseStart();
    waitDone(40);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("faulty_table2", ttA[0], 8'h33);
    checkOutput("faulty_match2", matchA[0], 1'b0);
    checkOutput("faulty_table0", ttA[1], 8'h33);

    $display("[TB] start while busy");
    mode = 0;
    b0 = busyCnt; d0 = doneCnt;
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 4);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 35);
    checkOutput("busy_start_dones2", 8'(doneCnt[0] - d0[0]), 8'd1);
    checkOutput("busy_start_dones0", 8'(doneCnt[1] - d0[1]), 8'd1);
    checkOutput("busy_start_len2", 8'(busyCnt[0] - b0[0]), 8'd24);
    checkOutput("busy_start_len0", 8'(busyCnt[1] - b0[1]), 8'd8);

    $display("[TB] reset in the middle of a sweep");
    pulseStart();
    c = 0;
    while ({xA[0], bA[0], dA[0]} != 3'd4 && c < 60) begin
      @(negedge clk);
      c++;
    end
    checkOutput("reach_idx4", {xA[0], bA[0], dA[0]}, 8'd4);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("midreset_busy", busyA[0], 1'b0);
    checkOutput("midreset_table", ttA[0], 8'h00);
    checkOutput("midreset_probes", {xA[0], bA[0], dA[0]}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1);
    b0 = busyCnt;
    pulseStart();
    waitDone(40);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("midreset_resweep_len", 8'(busyCnt[0] - b0[0]), 8'd24);
    checkOutput("midreset_resweep_table", ttA[0], 8'h31);

    $display("[TB] start held high");
    d0 = doneCnt;
    applyStimulus(1'b0, 1'b1, 0);
    c = 0;
    while (doneCnt[0] - d0[0] < 2 && c < 80) begin
      @(negedge clk);
      c++;
    end
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("held_start_dones", 8'(doneCnt[0] - d0[0]), 8'd2);
    applyStimulus(1'b0, 1'b0, 12);

    $display("[TB] late-settling circuit");
    mode = 2;
    pulseStart();
    waitDone(40);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("glitch_table2", ttA[0], 8'h39);
    checkOutput("glitch_unstable2", unstA[0], STAB_ON);
    checkOutput("glitch_unstable0", unstA[1], 1'b0);
    mode = 0;
    pulseStart();
    checkOutput("restart_unstable2", unstA[0], 1'b0);
    waitDone(40);
    applyStimulus(1'b0, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end

endmodule

// File: doc/blackbox_prober.md
Name: blackbox_prober

Overview:
- Sequential stimulus driver and response collector for a 3-input, 1-output combinational device under test.
- Sweeps all 8 input combinations {x,b,d} into the DUT and samples its output z after a programmable settle time.
- Assembles an 8-bit truth table and compares it against an expected table.
- Sits next to the gate-level lab circuits as the bench-side initiator that characterises them in hardware.

Parameters:
- SETTLE, 2, number of wait cycles after driving a vector before z is sampled; legal range 0..15.
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
- start  input  1  request a sweep; sampled only in IDLE.
- expected  input  8  reference truth table; bit i is the expected z for index i = {x,b,d}.
- probe_z  input  1  DUT output.
- probe_x  output  1  DUT input x, registered.
- probe_b  output  1  DUT input b, registered.
- probe_d  output  1  DUT input d, registered.
- busy  output  1  high while a sweep is in progress.
- done  output  1  single-cycle pulse when the sweep completes.
- truth_table  output  8  captured table; bit i holds z for index i.
- match  output  1  truth_table == expected; updated on the done cycle and held afterwards.
- unstable  output  1  stability flag; see Optional Feature.

Behaviour:
- Reset (synchronous, also mid-sweep):
  - State goes to IDLE; idx=0, cnt=0.
  - probe_x, probe_b and probe_d all go to 0.
  - busy, done, match and unstable go to 0; truth_table goes to 8'h00.
- States and transitions:
  - IDLE: busy=0. If start=1, clear truth_table, match and unstable, set idx=0 and cnt=0, then go to WAIT.
  - WAIT: busy=1; {probe_x,probe_b,probe_d} = idx.
    - While cnt < SETTLE: cnt increments each cycle.
    - When cnt == SETTLE: write probe_z into truth_table[idx] and reset cnt to 0.
    - If idx == 7, go to DONE; otherwise increment idx and stay in WAIT.
  - DONE: busy=0; done=1 for exactly this cycle; match <= (truth_table == expected), evaluated on the final table including bit 7; then go to IDLE.
- Probe outputs:
  - Registered; they change on the same edge that updates idx.
  - They hold the last vector (3'b111) after the sweep until the next start or reset.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - If start is sampled at edge T, busy is high for cycles T+1 .. T+8*(SETTLE+1) and done is high in cycle T+8*(SETTLE+1)+1.
- Boundary conditions:
  - start while busy or in DONE: ignored, with no queuing.
  - start held high continuously: a new sweep begins in the cycle after DONE returns to IDLE.
  - SETTLE=0: z is sampled in the first cycle each vector is driven, so the DUT must be purely combinational from the probe registers.
  - idx never wraps within a sweep; the exit is taken at idx==7.
- truth_table holds its contents between sweeps and is cleared only on sweep start or reset.

Optional Feature:
- Macro: BLACKBOX_PROBER_STABILITY_EN.
- With the macro defined:
  - WAIT also latches probe_z at cnt == SETTLE-1 into a shadow bit. For SETTLE=0 it latches at cnt==0 and compares the same sample, so no instability can be flagged.
  - If the sampled z differs from the shadow bit, unstable is set sticky until the next start or reset.
- Without the macro: unstable is tied to 0 and no shadow register exists.

Decomposition:
- Shared package blackbox_pkg:
  - state enum {IDLE, WAIT, DONE} in 2 bits;
  - localparam NUM_VEC=8 and IDX_W=3;
  - localparam BLACKBOX_GOLDEN = 8'h31, the golden table of the lab's reference circuit z = ~b & (x | ~d).
- Sub-module: blackbox_settle_counter, a CNT_W-bit counter with clear and terminal-count output (cnt == SETTLE). Everything else stays in one FSM module.

Test Plan:
- Golden DUT: model z = ~b&(x|~d), SETTLE=2, expected=8'h31, pulse start for one cycle.
  - busy is high for exactly 24 cycles; done pulses in the cycle after busy falls.
  - truth_table=8'h31 and match=1.
- Faulty DUT: z = ~b stuck-variant, expected=8'h31.
  - truth_table=8'h33 and match=0.
  - The probe sequence observed is 000, 001, … 111, each held for 3 cycles.
- Mid-sweep reset: assert reset at idx=4.
  - Next cycle: busy=0, truth_table=8'h00, probes=000.
  - A following start produces a full 8-vector sweep from idx 0.
- Start while busy: pulse start again at cycle T+5.
  - Ignored: exactly one done pulse, and total duration unchanged.
- SETTLE=0 with golden DUT.
  - busy is high for 8 cycles; truth_table=8'h31 and match=1.
- BLACKBOX_PROBER_STABILITY_EN defined, SETTLE=2: DUT z toggles between cnt 1 and 2 for idx 3.
  - unstable=1 and stays high after done.
  - unstable returns to 0 on the next start.
